// File: rtl/lamp_pkg.sv
// Shared encodings for the lamp sequencer: pattern modes, lamp index limits
// and the sequencer FSM states.
package lamp_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  localparam logic [3:0] NUM_OFF = 4'd0;
  localparam logic [3:0] NUM_MIN = 4'd1;
  localparam logic [3:0] NUM_MAX = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/lamp_sequencer_if.sv
// Control/status bundle between the user-control logic (master) and the
// lamp sequencer (slave).
interface lamp_sequencer_if;

  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] laps;
  logic [3:0] num;
  logic       busy;
  logic       step;
  logic       done;

  modport master (
    output start, stop, mode, laps,
    input  num, busy, step, done
  );

  modport slave (
    input  start, stop, mode, laps,
    output num, busy, step, done
  );

endinterface

// File: rtl/step_timer.sv
// Reloadable down-counter: ticks for one cycle every STEP_CYCLES cycles while
// clear is low, and sits at its reload value while clear is high.
module step_timer #(
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(STEP_CYCLES);
  localparam logic [W-1:0] RELOAD = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clear || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/lamp_sequencer.sv
// Lamp pattern sequencer: runs chase up / chase down / bounce for a latched
// number of laps (or forever) and presents the lit lamp index on num.
module lamp_sequencer #(
  parameter int STEP_CYCLES = 25_000_000
) (
  input logic             clk,
  input logic             rst_n,
  lamp_sequencer_if.slave bus
);

  import lamp_pkg::*;

  seq_state_t state, state_n;
  logic [3:0] pos, pos_n;
  logic       dir_down, dir_down_n;
  logic [3:0] lap_cnt, lap_n;
  logic [1:0] mode_r, mode_n;
  logic [3:0] laps_r, laps_n;
  logic       step_r, step_n;

  logic [3:0] adv_pos;
  logic       adv_dir_down;
  logic       boundary;
  logic [3:0] lap_inc;
  logic       tick;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != ST_RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pos      <= NUM_OFF;
      dir_down <= 1'b0;
      lap_cnt  <= 4'd0;
      mode_r   <= MODE_UP;
      laps_r   <= 4'd0;
      step_r   <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      dir_down <= dir_down_n;
      lap_cnt  <= lap_n;
      mode_r   <= mode_n;
      laps_r   <= laps_n;
      step_r   <= step_n;
    end
  end

  // Candidate next position and whether that advance closes a lap.
  always_comb begin
    adv_pos      = pos;
    adv_dir_down = dir_down;
    boundary     = 1'b0;
    case (mode_r)
      MODE_DOWN: begin
        boundary = (pos == NUM_MIN);
        adv_pos  = boundary ? NUM_MAX : pos - 4'd1;
      end
      MODE_BOUNCE: begin
        if (dir_down) begin
          adv_pos      = pos - 4'd1;
          boundary     = (pos == NUM_MIN + 4'd1);
          adv_dir_down = (pos != NUM_MIN + 4'd1);
        end else begin
          adv_pos      = pos + 4'd1;
          adv_dir_down = (pos == NUM_MAX - 4'd1);
        end
      end
      default: begin
        boundary = (pos == NUM_MAX);
        adv_pos  = boundary ? NUM_MIN : pos + 4'd1;
      end
    endcase
  end

  always_comb begin
    state_n    = state;
    pos_n      = pos;
    dir_down_n = dir_down;
    lap_n      = lap_cnt;
    mode_n     = mode_r;
    laps_n     = laps_r;
    step_n     = 1'b0;
    lap_inc    = lap_cnt + 4'd1;
    case (state)
      ST_IDLE: begin
        pos_n = NUM_OFF;
        if (bus.start && !bus.stop) begin
          state_n    = ST_RUN;
          mode_n     = bus.mode;
          laps_n     = bus.laps;
          lap_n      = 4'd0;
          dir_down_n = 1'b0;
          pos_n      = (bus.mode == MODE_DOWN) ? NUM_MAX : NUM_MIN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_n = ST_IDLE;
          pos_n   = NUM_OFF;
        end else if (tick) begin
          if (boundary && laps_r != 4'd0 && lap_inc == laps_r) begin
            state_n = ST_DONE;
            pos_n   = NUM_OFF;
          end else begin
            pos_n      = adv_pos;
            dir_down_n = adv_dir_down;
            step_n     = 1'b1;
            if (boundary && laps_r != 4'd0) begin
              lap_n = lap_inc;
            end
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        pos_n   = NUM_OFF;
      end
    endcase
  end

  assign bus.num  = pos;
  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.step = step_r;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed self-checking bench for lamp_sequencer with STEP_CYCLES = 4.
module tb_lamp_sequencer;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;
  int   failCount;
  int   expSeq[12];

  lamp_sequencer_if bus ();

  lamp_sequencer #(.STEP_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] l);
    bus.mode  = m;
    bus.laps  = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Runs one bounded pattern and checks every shown position, the busy
  // length, the step count and the one-cycle done pulse.
  task automatic runPattern(input string tag, input logic [1:0] m, input logic [3:0] l,
                            input int seqLen, input int expSteps, input bit perturb);
    int busyCount;
    int stepCount;
    busyCount = 0;
    stepCount = 0;
    applyStimulus(m, l);
    while (bus.busy && busyCount < 2000) begin
      checkOutput({tag, "_num"}, int'(bus.num), expSeq[(busyCount / 4) % seqLen]);
      stepCount += int'(bus.step);
      if (perturb && busyCount == 5) begin
        bus.mode = 2'd1;
        bus.laps = 4'd3;
      end
      busyCount++;
      tick();
    end
    checkOutput({tag, "_busy_len"}, busyCount, int'(l) * seqLen * 4);
    checkOutput({tag, "_steps"}, stepCount, expSteps);
    checkOutput({tag, "_done"}, int'(bus.done), 1);
    checkOutput({tag, "_done_num"}, int'(bus.num), 0);
    tick();
    checkOutput({tag, "_done_once"}, int'(bus.done), 0);
    bus.mode = 2'd0;
    bus.laps = 4'd0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.mode   = 2'd0;
    bus.laps   = 4'd0;
    repeat (3) tick();
    checkOutput("rst_num", int'(bus.num), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_step", int'(bus.step), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    expSeq = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0};
    runPattern("up1", 2'd0, 4'd1, 7, 6, 1'b0);
    tick();

    expSeq = '{7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
    runPattern("down2", 2'd1, 4'd2, 7, 13, 1'b0);
    tick();

    expSeq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2};
    runPattern("bounce1", 2'd2, 4'd1, 12, 11, 1'b0);
    tick();

    // Free-running up run with a stray start, stopped while showing 3.
    applyStimulus(2'd0, 4'd0);
    for (int c = 0; c <= 64; c++) begin
      checkOutput("forever_num", int'(bus.num), 1 + (c / 4) % 7);
      checkOutput("forever_busy", int'(bus.busy), 1);
      bus.start = (c == 10);
      if (c == 64) bus.stop = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checkOutput("stop_num", int'(bus.num), 0);
    checkOutput("stop_busy", int'(bus.busy), 0);
    checkOutput("stop_done", int'(bus.done), 0);
    tick();
    checkOutput("stop_done_later", int'(bus.done), 0);

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checkOutput("startstop_busy", int'(bus.busy), 0);
    tick();
    checkOutput("startstop_busy_later", int'(bus.busy), 0);

    expSeq = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0};
    runPattern("latch", 2'd0, 4'd1, 7, 6, 1'b1);
    tick();

    // Asynchronous reset while lamp 5 is lit.
    applyStimulus(2'd0, 4'd0);
    repeat (16) tick();
    checkOutput("prereset_num", int'(bus.num), 5);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_num", int'(bus.num), 0);
    checkOutput("async_rst_busy", int'(bus.busy), 0);
    checkOutput("async_rst_step", int'(bus.step), 0);
    checkOutput("async_rst_done", int'(bus.done), 0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("post_rst_busy", int'(bus.busy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lamp_sequencer.md
# lamp_sequencer

Sequencer that drives the 7-lamp display decoder with a lamp index (`num`, 0 = all off, 1..7 = one lamp lit). It runs one of three patterns (chase up, chase down, bounce) at a programmable step rate. A run lasts either a fixed number of laps or until it is stopped. It sits between the user-control logic (buttons/switches) and `lamp_display`, which turns its `num` output into active-low lamp drive.

## Interface
- `STEP_CYCLES`, default 25_000_000: clock cycles each position is held; legal range ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a run; honoured only in IDLE.
- `stop`  in  1  single-cycle abort request; honoured in RUN.
- `mode`  in  2  pattern: 0 chase up, 1 chase down, 2 bounce, 3 same as 0. Latched at start.
- `laps`  in  4  lap count, 0 = run forever. Latched at start.
- `num`  out  4  lamp index to `lamp_display`, registered.
- `busy`  out  1  high while in RUN.
- `step`  out  1  one-cycle pulse on every position advance inside a run.
- `done`  out  1  one-cycle pulse when the programmed lap count completes.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `num`=0, `busy`=0.
  - On `start`=1 and `stop`=0: latch `mode` and `laps`, clear the lap counter and the step timer, then go to RUN.
  - The first position is 1 for up and bounce, and 7 for down. Bounce direction initialises to up.
- RUN, position advance when the step timer expires:
  - Up: 1→2→…→7→1.
  - Down: 7→6→…→1→7.
  - Bounce: 1→…→7→6→…→2→1. Direction reverses on reaching 7 and on reaching 1.
- Lap boundary: the advance that would return to the start position (up 7→1, down 1→7, bounce 2→1).
  - At each lap boundary the lap counter (4-bit) increments.
  - If `laps`≠0 and the incremented count equals `laps`, the FSM goes to DONE instead of showing the start position.
  - If `laps`=0, the counter is frozen and the run continues forever.
- DONE: lasts exactly one cycle, with `done`=1, `num`=0 and `busy`=0. The FSM then goes to IDLE.
- `stop`=1 in RUN: go to IDLE on the next edge with `num`=0. No `done` pulse. This applies even on a cycle where the step timer expires, because stop has priority.
- `start` during RUN or DONE is ignored. `start` and `stop` asserted together in IDLE: stop wins and the FSM stays in IDLE.
- Changes on `mode` or `laps` during RUN have no effect until the next start.
- `step` pulses on every in-run advance. It does not pulse on the entry into RUN or on the advance that enters DONE.
- Reset (any time, including mid-run):
  - State IDLE, `num`=0, `busy`=0, `step`=0, `done`=0.
  - Timer and lap counter cleared, direction up.

## Timing
- Start latency: `start` is sampled high at edge N. At edge N+1 the outputs show `busy`=1 and `num`=first position.
- Each position is held for exactly STEP_CYCLES cycles. The timer runs from STEP_CYCLES−1 down to 0, advances on 0, and reloads.
- Run length for `laps`=L≥1:
  - Chase up and chase down: `busy` is high for L·7·STEP_CYCLES cycles.
  - Bounce: `busy` is high for L·12·STEP_CYCLES cycles.
- `done` is asserted in the first cycle after `busy` falls. The FSM can accept a new `start` one cycle after `done`, i.e. while in IDLE.
- Stop latency: `stop` is sampled at edge N. At edge N+1 the outputs show `busy`=0 and `num`=0.
- Timer width is $clog2(STEP_CYCLES). No combinational path from inputs to outputs.

## Structure
- The shared package `lamp_pkg` holds:
  - mode encodings MODE_UP=0, MODE_DOWN=1, MODE_BOUNCE=2;
  - NUM_OFF=0, NUM_MIN=1, NUM_MAX=7;
  - the FSM state enum.
- Sub-module `step_timer` (parameter STEP_CYCLES; ports `clk`, `rst_n`, `clear`, `tick`): a reloadable down-counter that outputs a one-cycle `tick`. The sequencer holds `clear` high outside RUN.
- `lamp_sequencer` contains the FSM, the position/direction registers and the lap counter. `num` connects directly to `lamp_display.num` at the top level.

## Test plan
All scenarios use STEP_CYCLES=4.
- Reset mid-run: assert `rst_n`=0 while `num`=5. Required: `num`=0, `busy`=0, `step`=0 and `done`=0 immediately, before the next clock edge.
- Chase up, `laps`=1, single `start` pulse. Required:
  - `num` steps 1,2,…,7, four cycles each;
  - `step` pulses 6 times;
  - then `done`=1 for one cycle with `num`=0;
  - `busy` high for 28 cycles.
- Down, `laps`=2. Required: `num` runs 7..1 twice, then `done`; `busy` high for 56 cycles.
- Bounce, `laps`=1. Required: `num` shows 1,2,3,4,5,6,7,6,5,4,3,2, then `done`; `busy` high for 48 cycles.
- `laps`=0 with up mode, `stop` pulsed while `num`=3:
  - Before stop: `num` wraps 7→1 at least twice.
  - After stop: the next cycle shows `num`=0 and `busy`=0, with no `done`.
  - Also: `start` pulsed during RUN causes no restart. `start` and `stop` asserted together in IDLE leave `busy` low.
- Latching: change `mode` from 0 to 1 and `laps` from 1 to 3 during RUN. Required: the run continues as up, ends after one lap, and `done` fires at cycle 28.
